phv_act_pair_sched: RTL and testbench

- Pairs the PHV stream from the parser or previous stage with the per-container action word from the lookup engine, then issues one aligned pair per transfer into the stage crossbar.
- The crossbar consumes phv_in and action_in in the same cycle and back-pressures through its registered ready_out, so this block buffers both streams and holds each pair stable until it is accepted.
- Detects stream skew (one side starved past a timeout), drops the orphan, and keeps sticky error and statistics counters.

---
 rtl/phv_act_pair_sched.sv | 185 ++++++++++++++++++
 tb/tb_phv_act_pair_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phv_act_pair_sched.sv
// Pairs the PHV stream with the per-container action word and issues one aligned
// pair per crossbar transfer; drops an orphan head when one side starves too long.

module phv_act_pair_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;
  assign dout_o  = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module phv_act_pair_sched #(
  parameter int PHV_LEN    = 2304,
  parameter int ACT_LEN    = 64,
  parameter int C_NUM_PHVS = 65,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_in_valid,
  output logic                          phv_ready,
  input  logic [ACT_LEN*C_NUM_PHVS-1:0] act_in,
  input  logic                          act_in_valid,
  output logic                          act_ready,
  output logic [PHV_LEN-1:0]            xbar_phv,
  output logic [ACT_LEN*C_NUM_PHVS-1:0] xbar_act,
  output logic                          xbar_valid,
  input  logic                          xbar_ready,
  input  logic                          flush,
  output logic                          err_skew,
  output logic [31:0]                   pair_cnt,
  output logic [15:0]                   drop_cnt
);
  localparam int AW_TOT = ACT_LEN * C_NUM_PHVS;
  localparam int TW     = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic {ST_RUN, ST_DROP} state_e;

  state_e              state_q;
  logic [TW-1:0]       timer_q, timer_d;
  logic                xbar_valid_q, err_skew_q;
  logic [PHV_LEN-1:0]  xbar_phv_q;
  logic [AW_TOT-1:0]   xbar_act_q;
  logic [31:0]         pair_cnt_q;
  logic [15:0]         drop_cnt_q;

  logic [PHV_LEN-1:0]  phv_head;
  logic [AW_TOT-1:0]   act_head;
  logic phv_empty, phv_full, act_empty, act_full;
  logic phv_push, act_push, phv_pop, act_pop;
  logic issue, drop_now, skew, missing_push, go_drop;

  assign phv_ready = rst_n && !phv_full;
  assign act_ready = rst_n && !act_full;
  assign phv_push  = phv_in_valid && phv_ready && !flush;
  assign act_push  = act_in_valid && act_ready && !flush;

  assign issue    = !phv_empty && !act_empty && (!xbar_valid_q || xbar_ready)
                    && (state_q == ST_RUN) && !flush;
  assign drop_now = (state_q == ST_DROP) && !flush;
  assign phv_pop  = issue || (drop_now && !phv_empty && act_empty);
  assign act_pop  = issue || (drop_now && !act_empty && phv_empty);

  // A drop is cancelled when the starved side arrives on the very edge the timer expires.
  assign skew         = phv_empty ^ act_empty;
  assign missing_push = phv_empty ? phv_push : act_push;
  assign go_drop      = (TIMEOUT != 0) && skew && !missing_push && !flush
                        && (timer_q >= TMAX - 1'b1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    timer_d = '0;
    if (skew) timer_d = (timer_q == TMAX) ? timer_q : timer_q + 1'b1;
  end

  phv_act_pair_fifo #(.W(PHV_LEN), .DEPTH(DEPTH)) u_phv_fifo (
    .clk(clk), .rst_n(rst_n), .clr_i(flush), .push_i(phv_push), .din_i(phv_in),
    .pop_i(phv_pop), .dout_o(phv_head), .empty_o(phv_empty), .full_o(phv_full)
  );

  phv_act_pair_fifo #(.W(AW_TOT), .DEPTH(DEPTH)) u_act_fifo (
    .clk(clk), .rst_n(rst_n), .clr_i(flush), .push_i(act_push), .din_i(act_in),
    .pop_i(act_pop), .dout_o(act_head), .empty_o(act_empty), .full_o(act_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      timer_q      <= '0;
      xbar_valid_q <= 1'b0;
      xbar_phv_q   <= '0;
      xbar_act_q   <= '0;
      err_skew_q   <= 1'b0;
      pair_cnt_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (xbar_valid_q && xbar_ready) pair_cnt_q <= pair_cnt_q + 32'd1;
      if (flush) begin
        state_q      <= ST_RUN;
        timer_q      <= '0;
        xbar_valid_q <= 1'b0;
        xbar_phv_q   <= '0;
        xbar_act_q   <= '0;
      end else begin
        if (issue) begin
          xbar_valid_q <= 1'b1;
          xbar_phv_q   <= phv_head;
          xbar_act_q   <= act_head;
        end else if (xbar_ready) begin
          xbar_valid_q <= 1'b0;
        end
        case (state_q)
          ST_RUN: begin
            timer_q <= timer_d;
            if (go_drop) state_q <= ST_DROP;
          end
          ST_DROP: begin
            state_q    <= ST_RUN;
            timer_q    <= '0;
            err_skew_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
          end
          default: state_q <= ST_RUN;
        endcase
      end
    end
  end

  assign xbar_valid = xbar_valid_q;
  assign xbar_phv   = xbar_phv_q;
  assign xbar_act   = xbar_act_q;
  assign err_skew   = err_skew_q;
  assign pair_cnt   = pair_cnt_q;
  assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_phv_act_pair_sched.sv
// Directed bench for phv_act_pair_sched: pairing, streaming, back-pressure,
// skew drop, exact-timeout arrival, flush and asynchronous reset.

module tb_phv_act_pair_sched;
  localparam int PL = 32;
  localparam int AL = 8;
  localparam int CN = 4;
  localparam int AT = AL * CN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PL-1:0] phv_in;
  logic          phv_in_valid;
  logic          phv_ready;
  logic [AT-1:0] act_in;
  logic          act_in_valid;
  logic          act_ready;
  logic [PL-1:0] xbar_phv;
  logic [AT-1:0] xbar_act;
  logic          xbar_valid;
  logic          xbar_ready;
  logic          flush;
  logic          err_skew;
  logic [31:0]   pair_cnt;
  logic [15:0]   drop_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  phv_act_pair_sched #(
    .PHV_LEN(PL), .ACT_LEN(AL), .C_NUM_PHVS(CN), .DEPTH(4), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_ready(phv_ready),
    .act_in(act_in), .act_in_valid(act_in_valid), .act_ready(act_ready),
    .xbar_phv(xbar_phv), .xbar_act(xbar_act), .xbar_valid(xbar_valid),
    .xbar_ready(xbar_ready), .flush(flush), .err_skew(err_skew),
    .pair_cnt(pair_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [PL-1:0] pd,
                       input logic av, input logic [AT-1:0] ad);
    phv_in_valid = pv; phv_in = pd;
    act_in_valid = av; act_in = ad;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; xbar_ready = 1'b1; flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    #3;
    tests_run++;
    if (phv_ready !== 1'b0 || act_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: phv_ready=%b act_ready=%b expected 0/0", phv_ready, act_ready);
    end
    tests_run++;
    if (xbar_valid !== 1'b0 || xbar_phv !== '0 || xbar_act !== '0) begin
      tests_failed++;
      $display("FAIL reset_out: valid=%b phv=%h act=%h expected 0", xbar_valid, xbar_phv, xbar_act);
    end
    tests_run++;
    if (pair_cnt !== 32'd0 || drop_cnt !== 16'd0 || err_skew !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cnt: pair=%0d drop=%0d err=%b expected 0", pair_cnt, drop_cnt, err_skew);
    end
    #19 rst_n = 1'b1;
    #1;
    tests_run++;
    if (phv_ready !== 1'b1 || act_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_ready: phv_ready=%b act_ready=%b expected 1/1", phv_ready, act_ready);
    end
  endtask

  task automatic test_basic_pair();
    drive(1'b1, 32'hA000_0001, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b1, 32'h1000_0001);
    step();
    drive(1'b0, '0, 1'b0, '0);
    tests_run++;
    if (xbar_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_latency: valid=%b expected 0", xbar_valid);
    end
    step();
    tests_run++;
    if (xbar_valid !== 1'b1 || xbar_phv !== 32'hA000_0001 || xbar_act !== 32'h1000_0001) begin
      tests_failed++;
      $display("FAIL basic_issue: valid=%b phv=%h act=%h expected 1/a0000001/10000001",
               xbar_valid, xbar_phv, xbar_act);
    end
    step();
    tests_run++;
    if (xbar_valid !== 1'b0 || pair_cnt !== 32'd1) begin
      tests_failed++;
      $display("FAIL basic_done: valid=%b pair_cnt=%0d expected 0/1", xbar_valid, pair_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 32'hB000_0000 + i, 1'b1, 32'h2000_0000 + i);
      else       drive(1'b0, '0, 1'b0, '0);
      step();
      if (i >= 1 && i <= 8) begin
        tests_run++;
        if (xbar_valid !== 1'b1 || xbar_phv !== 32'hB000_0000 + (i - 1)
            || xbar_act !== 32'h2000_0000 + (i - 1)) begin
          tests_failed++;
          $display("FAIL b2b_pair%0d: valid=%b phv=%h act=%h expected 1/%h/%h", i - 1,
                   xbar_valid, xbar_phv, xbar_act, 32'hB000_0000 + (i - 1), 32'h2000_0000 + (i - 1));
        end
      end
    end
    tests_run++;
    if (xbar_valid !== 1'b0 || pair_cnt !== 32'd9 || err_skew !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: valid=%b pair_cnt=%0d err=%b expected 0/9/0", xbar_valid, pair_cnt, err_skew);
    end
  endtask

  task automatic test_backpressure();
    xbar_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'hC100_0000 + i, 1'b1, 32'h3100_0000 + i);
      tests_run++;
      if (phv_ready !== (i < 5) || act_ready !== (i < 5)) begin
        tests_failed++;
        $display("FAIL bp_ready%0d: phv_ready=%b act_ready=%b expected %0d", i, phv_ready, act_ready, i < 5);
      end
      step();
    end
    drive(1'b0, '0, 1'b0, '0);
    for (int h = 0; h < 2; h++) begin
      tests_run++;
      if (xbar_valid !== 1'b1 || xbar_phv !== 32'hC100_0000 || xbar_act !== 32'h3100_0000) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: valid=%b phv=%h act=%h expected 1/c1000000/31000000",
                 h, xbar_valid, xbar_phv, xbar_act);
      end
      step();
    end
    xbar_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      tests_run++;
      if (xbar_valid !== 1'b1 || xbar_phv !== 32'hC100_0000 + k || xbar_act !== 32'h3100_0000 + k) begin
        tests_failed++;
        $display("FAIL bp_drain%0d: valid=%b phv=%h act=%h expected 1/%h/%h", k,
                 xbar_valid, xbar_phv, xbar_act, 32'hC100_0000 + k, 32'h3100_0000 + k);
      end
    end
    step();
    tests_run++;
    if (xbar_valid !== 1'b0 || pair_cnt !== 32'd14) begin
      tests_failed++;
      $display("FAIL bp_end: valid=%b pair_cnt=%0d expected 0/14", xbar_valid, pair_cnt);
    end
  endtask

  task automatic test_skew_drop();
    drive(1'b1, 32'hC0C0_C0C0, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    for (int s = 1; s <= 5; s++) begin
      step();
      tests_run++;
      if (drop_cnt !== ((s == 5) ? 16'd1 : 16'd0)) begin
        tests_failed++;
        $display("FAIL drop_cycle%0d: drop_cnt=%0d expected %0d", s, drop_cnt, (s == 5) ? 1 : 0);
      end
    end
    tests_run++;
    if (err_skew !== 1'b1 || xbar_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_err: err_skew=%b valid=%b expected 1/0", err_skew, xbar_valid);
    end
    drive(1'b1, 32'hD1D1_D1D1, 1'b1, 32'h3131_3131);
    step();
    drive(1'b0, '0, 1'b0, '0);
    step();
    tests_run++;
    if (xbar_valid !== 1'b1 || xbar_phv !== 32'hD1D1_D1D1 || xbar_act !== 32'h3131_3131) begin
      tests_failed++;
      $display("FAIL drop_next_pair: valid=%b phv=%h act=%h expected 1/d1d1d1d1/31313131",
               xbar_valid, xbar_phv, xbar_act);
    end
    step();
  endtask

  task automatic test_exact_timeout();
    drive(1'b1, 32'hE0E0_E0E0, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    step(); step(); step();
    drive(1'b0, '0, 1'b1, 32'h4444_4444);
    step();
    drive(1'b0, '0, 1'b0, '0);
    tests_run++;
    if (drop_cnt !== 16'd1 || xbar_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_arrive: drop_cnt=%0d valid=%b expected 1/0", drop_cnt, xbar_valid);
    end
    step();
    tests_run++;
    if (xbar_valid !== 1'b1 || xbar_phv !== 32'hE0E0_E0E0 || xbar_act !== 32'h4444_4444) begin
      tests_failed++;
      $display("FAIL edge_issue: valid=%b phv=%h act=%h expected 1/e0e0e0e0/44444444",
               xbar_valid, xbar_phv, xbar_act);
    end
    step();
    tests_run++;
    if (drop_cnt !== 16'd1 || xbar_valid !== 1'b0 || pair_cnt !== 32'd16) begin
      tests_failed++;
      $display("FAIL edge_done: drop_cnt=%0d valid=%b pair_cnt=%0d expected 1/0/16",
               drop_cnt, xbar_valid, pair_cnt);
    end
  endtask

  task automatic test_flush();
    xbar_ready = 1'b0;
    drive(1'b1, 32'hF000_0000, 1'b1, 32'h5000_0000);
    step();
    drive(1'b1, 32'hF000_0001, 1'b1, 32'h5000_0001);
    step();
    drive(1'b1, 32'hF000_0002, 1'b0, '0);
    step();
    drive(1'b1, 32'hF000_0003, 1'b0, '0);
    step();
    tests_run++;
    if (xbar_valid !== 1'b1 || xbar_phv !== 32'hF000_0000) begin
      tests_failed++;
      $display("FAIL flush_setup: valid=%b phv=%h expected 1/f0000000", xbar_valid, xbar_phv);
    end
    flush = 1'b1;
    drive(1'b1, 32'h9999_9999, 1'b1, 32'h9999_9999);
    step();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    tests_run++;
    if (xbar_valid !== 1'b0 || pair_cnt !== 32'd16) begin
      tests_failed++;
      $display("FAIL flush_clear: valid=%b pair_cnt=%0d expected 0/16", xbar_valid, pair_cnt);
    end
    xbar_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      step();
      tests_run++;
      if (xbar_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_empty%0d: valid=%b expected 0", w, xbar_valid);
      end
    end
    tests_run++;
    if (drop_cnt !== 16'd1 || err_skew !== 1'b1 || pair_cnt !== 32'd16) begin
      tests_failed++;
      $display("FAIL flush_keep: drop=%0d err=%b pair=%0d expected 1/1/16", drop_cnt, err_skew, pair_cnt);
    end
  endtask

  task automatic test_reset_mid();
    xbar_ready = 1'b0;
    drive(1'b1, 32'h7777_7777, 1'b1, 32'h7777_7777);
    step();
    drive(1'b0, '0, 1'b0, '0);
    step();
    tests_run++;
    if (xbar_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_setup: valid=%b expected 1", xbar_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (xbar_valid !== 1'b0 || xbar_phv !== '0 || xbar_act !== '0 || phv_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: valid=%b phv=%h act=%h phv_ready=%b expected 0",
               xbar_valid, xbar_phv, xbar_act, phv_ready);
    end
    tests_run++;
    if (pair_cnt !== 32'd0 || drop_cnt !== 16'd0 || err_skew !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_cnt: pair=%0d drop=%0d err=%b expected 0", pair_cnt, drop_cnt, err_skew);
    end
    #1 rst_n = 1'b1;
    xbar_ready = 1'b1;
    #1;
    tests_run++;
    if (phv_ready !== 1'b1 || act_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_release: phv_ready=%b act_ready=%b expected 1/1", phv_ready, act_ready);
    end
    step();
    tests_run++;
    if (xbar_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_empty: valid=%b expected 0", xbar_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_back_to_back();
    test_backpressure();
    test_skew_drop();
    test_exact_timeout();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
